// File: rtl/tick_gen_pkg.sv
// Shared constants and types for the multi-channel tick generator.
// Default divisors assume a 100 MHz system clock.
package tick_gen_pkg;

    localparam int CNT_W_DEF = 32;

    localparam logic [31:0] DIV_1HZ  = 32'd100_000_000;
    localparam logic [31:0] DIV_2HZ  = 32'd50_000_000;
    localparam logic [31:0] DIV_1KHZ = 32'd100_000;

    typedef enum logic {
        CFG_IDLE = 1'b0,
        CFG_PEND = 1'b1
    } cfg_state_t;

    // Channel-select width, never narrower than one bit.
    function automatic int ch_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/tick_gen_multi_if.sv
// Divisor-update port of the tick generator: valid/ready request plus an
// error pulse for rejected requests.
interface tick_gen_multi_if
    import tick_gen_pkg::*;
#(
    parameter int NUM_CH = 3,
    parameter int CNT_W  = CNT_W_DEF
);
    localparam int CH_W = ch_width(NUM_CH);

    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_err;

    modport master (
        output cfg_valid, cfg_ch, cfg_div,
        input  cfg_ready, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_div,
        output cfg_ready, cfg_err
    );

endinterface

// File: rtl/tick_gen_ch.sv
// One tick channel: free-running counter, reloadable divisor and, with
// TICK_GEN_SQUARE_EN defined, a square-wave flop toggled on every tick.
module tick_gen_ch
    import tick_gen_pkg::*;
#(
    parameter int               CNT_W   = CNT_W_DEF,
    parameter logic [CNT_W-1:0] DIV_RST = 1
) (
    input  logic             sys_clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sync_clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_div,
    output logic             wrap,
    output logic             tick_en
`ifdef TICK_GEN_SQUARE_EN
    ,
    output logic             tick_sq
`endif
);

    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [CNT_W-1:0] div_reg, div_next;
    logic             tick_reg, tick_next;

    // Wrap is exported so the config FSM can time a glitch-free reload.
    assign wrap = en && (cnt_reg == div_reg - CNT_W'(1));

    always_comb begin
        div_next  = load ? load_div : div_reg;
        tick_next = wrap && !sync_clr;
        if (sync_clr || load || wrap) begin
            cnt_next = '0;
        end else if (en) begin
            cnt_next = cnt_reg + CNT_W'(1);
        end else begin
            cnt_next = cnt_reg;
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg  <= '0;
            div_reg  <= DIV_RST;
            tick_reg <= 1'b0;
        end else begin
            cnt_reg  <= cnt_next;
            div_reg  <= div_next;
            tick_reg <= tick_next;
        end
    end

    assign tick_en = tick_reg;

`ifdef TICK_GEN_SQUARE_EN
    logic sq_reg;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            sq_reg <= 1'b0;
        end else if (sync_clr) begin
            sq_reg <= 1'b0;
        end else begin
            sq_reg <= sq_reg ^ tick_next;
        end
    end

    assign tick_sq = sq_reg;
`endif

endmodule

// File: rtl/tick_gen_multi.sv
// Multi-channel tick generator with run-time divisor reload; optional square
// outputs are enabled by defining TICK_GEN_SQUARE_EN.
module tick_gen_multi
    import tick_gen_pkg::*;
#(
    parameter int                      NUM_CH  = 3,
    parameter int                      CNT_W   = CNT_W_DEF,
    parameter logic [NUM_CH*CNT_W-1:0] DIV_RST = {DIV_1KHZ, DIV_2HZ, DIV_1HZ}
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              sync_clr,
    tick_gen_multi_if.slave   cfg,
    output logic [NUM_CH-1:0] tick_en
`ifdef TICK_GEN_SQUARE_EN
    ,
    output logic [NUM_CH-1:0] tick_sq
`endif
);

    localparam int CH_W = ch_width(NUM_CH);

    cfg_state_t       state_reg;
    logic [CH_W-1:0]  pend_ch_reg;
    logic [CNT_W-1:0] pend_div_reg;
    logic             ready_reg;
    logic             err_reg;

    logic [NUM_CH-1:0] wrap;
    logic [NUM_CH-1:0] sel;
    logic [NUM_CH-1:0] load;
    logic              req_bad;

    assign req_bad = (int'(cfg.cfg_ch) >= NUM_CH) || (cfg.cfg_div == '0);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            // A held or realigned counter has no wrap to wait for, so the
            // reload goes in at once in those cases.
            assign sel[gi]  = (state_reg == CFG_PEND) && (pend_ch_reg == CH_W'(gi));
            assign load[gi] = sel[gi] && (wrap[gi] || !en || sync_clr);

            tick_gen_ch #(
                .CNT_W   (CNT_W),
                .DIV_RST (DIV_RST[gi*CNT_W +: CNT_W])
            ) u_ch (
                .sys_clk  (sys_clk),
                .rst_n    (rst_n),
                .en       (en),
                .sync_clr (sync_clr),
                .load     (load[gi]),
                .load_div (pend_div_reg),
                .wrap     (wrap[gi]),
                .tick_en  (tick_en[gi])
`ifdef TICK_GEN_SQUARE_EN
                ,
                .tick_sq  (tick_sq[gi])
`endif
            );
        end
    endgenerate

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= CFG_IDLE;
            pend_ch_reg  <= '0;
            pend_div_reg <= '0;
            ready_reg    <= 1'b1;
            err_reg      <= 1'b0;
        end else begin
            err_reg <= 1'b0;
            case (state_reg)
                CFG_IDLE: begin
                    if (cfg.cfg_valid && ready_reg) begin
                        if (req_bad) begin
                            err_reg <= 1'b1;
                        end else begin
                            state_reg    <= CFG_PEND;
                            pend_ch_reg  <= cfg.cfg_ch;
                            pend_div_reg <= cfg.cfg_div;
                            ready_reg    <= 1'b0;
                        end
                    end
                end
                CFG_PEND: begin
                    if (|load) begin
                        state_reg <= CFG_IDLE;
                        ready_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= CFG_IDLE;
                    ready_reg <= 1'b1;
                end
            endcase
        end
    end

    assign cfg.cfg_ready = ready_reg;
    assign cfg.cfg_err   = err_reg;

endmodule
